// File: rtl/sincos_pkg.sv
// sincos_pkg: ATAN table, CORDIC gain constant, Q8 limits and FSM states for sincos_cordic.
package sincos_pkg;
    localparam int ONE_Q8       = 256;
    localparam int MINUS_ONE_Q8 = -256;

    typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_DONE} state_t;

    // atan(2^-i) in units of 1/65536 turn
    function automatic logic [16:0] atan_lut(input logic [3:0] i);
        case (i)
            4'd0:    return 17'd8192;
            4'd1:    return 17'd4836;
            4'd2:    return 17'd2555;
            4'd3:    return 17'd1297;
            4'd4:    return 17'd651;
            4'd5:    return 17'd326;
            4'd6:    return 17'd163;
            4'd7:    return 17'd81;
            4'd8:    return 17'd41;
            4'd9:    return 17'd20;
            4'd10:   return 17'd10;
            4'd11:   return 17'd5;
            4'd12:   return 17'd3;
            4'd13:   return 17'd1;
            4'd14:   return 17'd1;
            default: return 17'd0;
        endcase
    endfunction

    function automatic int k_const(input int frac);
        return $rtoi(0.6072529 * $itor(1 << frac) + 0.5);
    endfunction
endpackage

// File: rtl/cordic_stage.sv
// cordic_stage: one combinational CORDIC micro-rotation in rotation mode.
module cordic_stage
    import sincos_pkg::*;
#(
    parameter int W = 17
) (
    input  logic signed [W-1:0] i_x,
    input  logic signed [W-1:0] i_y,
    input  logic signed [16:0]  i_z,
    input  logic        [3:0]   i_i,
    output logic signed [W-1:0] o_x,
    output logic signed [W-1:0] o_y,
    output logic signed [16:0]  o_z
);
    logic signed [W-1:0] w_xs, w_ys;
    logic signed [16:0]  w_atan;
    logic                w_d;

    assign w_xs   = i_x >>> i_i;
    assign w_ys   = i_y >>> i_i;
    assign w_atan = signed'(atan_lut(i_i));
    assign w_d    = ~i_z[16];
    assign o_x    = w_d ? i_x - w_ys : i_x + w_ys;
    assign o_y    = w_d ? i_y + w_xs : i_y - w_xs;
    assign o_z    = w_d ? i_z - w_atan : i_z + w_atan;
endmodule

// File: rtl/sincos_cordic.sv
// sincos_cordic: iterative CORDIC angle -> Q8 sin/cos; SINCOS_ROUND_EN selects round-half-up
// instead of truncating Q8 conversion.
module sincos_cordic
    import sincos_pkg::*;
#(
    parameter int ITER = 14,
    parameter int FRAC = 14
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic        [15:0] angle_in,
    input  logic               angle_valid_in,
    output logic               angle_ready_out,
    output logic signed [15:0] sin_out,
    output logic signed [15:0] cos_out,
    output logic               valid_out
);
    localparam int W  = FRAC + 3;
    localparam int SH = FRAC - 8;
    localparam logic signed [W-1:0] K_X = W'(k_const(FRAC));

    state_t              r_state;
    logic signed [W-1:0] r_x, r_y;
    logic signed [16:0]  r_z;
    logic        [3:0]   r_i;
    logic                r_flip;

    logic signed [W-1:0] w_x_n, w_y_n;
    logic signed [16:0]  w_z_n, w_z0;
    logic signed [15:0]  w_zf, w_cos, w_sin;
    logic signed [W:0]   w_xe, w_ye, w_cx, w_sy, w_cn, w_sn;
    logic                w_flip;

    cordic_stage #(.W(W)) u_stage (
        .i_x(r_x), .i_y(r_y), .i_z(r_z), .i_i(r_i),
        .o_x(w_x_n), .o_y(w_y_n), .o_z(w_z_n)
    );

    // Fold quadrants 1 and 2 onto the +/-90 deg range and negate the result later
    assign w_flip = angle_in[15] ^ angle_in[14];
    assign w_zf   = signed'(w_flip ? angle_in ^ 16'h8000 : angle_in);
    assign w_z0   = w_zf;

    assign w_xe = r_x;
    assign w_ye = r_y;
`ifdef SINCOS_ROUND_EN
    localparam logic signed [W:0] RND = (W+1)'(1 << (FRAC - 9));
    assign w_cx = (w_xe + RND) >>> SH;
    assign w_sy = (w_ye + RND) >>> SH;
`else
    assign w_cx = w_xe >>> SH;
    assign w_sy = w_ye >>> SH;
`endif
    assign w_cn  = r_flip ? -w_cx : w_cx;
    assign w_sn  = r_flip ? -w_sy : w_sy;
    assign w_cos = w_cn > ONE_Q8 ? 16'(ONE_Q8) : w_cn < MINUS_ONE_Q8 ? 16'(MINUS_ONE_Q8) : w_cn[15:0];
    assign w_sin = w_sn > ONE_Q8 ? 16'(ONE_Q8) : w_sn < MINUS_ONE_Q8 ? 16'(MINUS_ONE_Q8) : w_sn[15:0];

    assign angle_ready_out = r_state == S_IDLE;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state   <= S_IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_i       <= '0;
            r_flip    <= 1'b0;
            sin_out   <= '0;
            cos_out   <= 16'(ONE_Q8);
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (r_state)
                S_IDLE: if (angle_valid_in) begin
                    r_x     <= K_X;
                    r_y     <= '0;
                    r_z     <= w_z0;
                    r_i     <= '0;
                    r_flip  <= w_flip;
                    r_state <= S_ROTATE;
                end
                S_ROTATE: begin
                    r_x <= w_x_n;
                    r_y <= w_y_n;
                    r_z <= w_z_n;
                    r_i <= r_i + 4'd1;
                    if (r_i == 4'(ITER - 1)) r_state <= S_DONE;
                end
                S_DONE: begin
                    sin_out   <= w_sin;
                    cos_out   <= w_cos;
                    valid_out <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sincos_cordic.sv
// tb_sincos_cordic: directed self-checking bench for sincos_cordic.
module tb_sincos_cordic;
    logic               clk_in = 0;
    logic               rst_in = 1;
    logic        [15:0] angle_in = '0;
    logic               angle_valid_in = 0;
    logic               angle_ready_out;
    logic signed [15:0] sin_out, cos_out;
    logic               valid_out;

    int n_cmp = 0;
    int n_bad = 0;

    sincos_cordic dut (
        .clk_in(clk_in), .rst_in(rst_in), .angle_in(angle_in),
        .angle_valid_in(angle_valid_in), .angle_ready_out(angle_ready_out),
        .sin_out(sin_out), .cos_out(cos_out), .valid_out(valid_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #3000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic run_angle(input logic [15:0] a, output int s, output int c, output int lat);
        int n = 0;
        while (!angle_ready_out && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        angle_in = a;
        angle_valid_in = 1;
        @(negedge clk_in);
        angle_valid_in = 0;
        lat = 0;
        while (!valid_out && lat < 40) begin
            @(negedge clk_in);
            lat++;
        end
        s = sin_out;
        c = cos_out;
    endtask

    task automatic test_reset();
        rst_in = 1;
        repeat (2) @(negedge clk_in);
        n_cmp += 4;
        if (sin_out !== 16'sd0) begin n_bad++; $display("FAIL reset_sin got %0d want 0", sin_out); end
        if (cos_out !== 16'sd256) begin n_bad++; $display("FAIL reset_cos got %0d want 256", cos_out); end
        if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", valid_out); end
        if (angle_ready_out !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", angle_ready_out); end
        rst_in = 0;
        @(negedge clk_in);
    endtask

    task automatic test_axis_diag();
        logic [15:0] ang [7] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h2000, 16'hE000, 16'hA000};
        int es [7] = '{0, 256, 0, -256, 181, -181, -181};
        int ec [7] = '{256, 0, -256, 0, 181, 181, -181};
        int s, c, lat;
        for (int k = 0; k < 7; k++) begin
            run_angle(ang[k], s, c, lat);
            n_cmp += 3;
            if (lat !== 15) begin n_bad++; $display("FAIL latency_%h got %0d want 15", ang[k], lat); end
            if (s < es[k] - 2 || s > es[k] + 1) begin n_bad++; $display("FAIL sin_%h got %0d want %0d", ang[k], s, es[k]); end
            if (c < ec[k] - 2 || c > ec[k] + 1) begin n_bad++; $display("FAIL cos_%h got %0d want %0d", ang[k], c, ec[k]); end
        end
    endtask

    task automatic test_hold_during_rotate();
        int lat = 0;
        int s, c;
        while (!angle_ready_out) @(negedge clk_in);
        angle_in = 16'h2000;
        angle_valid_in = 1;
        @(negedge clk_in);
        while (lat < 40) begin
            @(negedge clk_in);
            lat++;
            if (valid_out) break;
            angle_in = 16'($urandom);
            angle_valid_in = 1'($urandom);
        end
        angle_valid_in = 0;
        s = sin_out;
        c = cos_out;
        n_cmp += 3;
        if (lat !== 15) begin n_bad++; $display("FAIL hold_latency got %0d want 15", lat); end
        if (s < 179 || s > 182) begin n_bad++; $display("FAIL hold_sin got %0d want 181", s); end
        if (c < 179 || c > 182) begin n_bad++; $display("FAIL hold_cos got %0d want 181", c); end
        @(negedge clk_in);
        n_cmp += 2;
        if (valid_out !== 1'b0) begin n_bad++; $display("FAIL valid_pulse_width got %b want 0", valid_out); end
        if (sin_out !== 16'(s)) begin n_bad++; $display("FAIL hold_stable got %0d want %0d", sin_out, s); end
    endtask

    task automatic test_back_to_back();
        int s, c, lat, gap;
        run_angle(16'h0000, s, c, lat);
        n_cmp += 2;
        if (c < 254 || c > 256) begin n_bad++; $display("FAIL b2b_first_cos got %0d want 256", c); end
        if (angle_ready_out !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_in_valid_cycle got %b want 1", angle_ready_out); end
        angle_in = 16'h4000;
        angle_valid_in = 1;
        @(negedge clk_in);
        angle_valid_in = 0;
        n_cmp++;
        if (angle_ready_out !== 1'b0) begin n_bad++; $display("FAIL b2b_accept got ready %b want 0", angle_ready_out); end
        gap = 1;
        while (!valid_out && gap < 40) begin
            @(negedge clk_in);
            gap++;
        end
        s = sin_out;
        c = cos_out;
        n_cmp += 3;
        if (gap !== 16) begin n_bad++; $display("FAIL b2b_gap got %0d want 16", gap); end
        if (s < 254 || s > 256) begin n_bad++; $display("FAIL b2b_sin got %0d want 256", s); end
        if (c < -2 || c > 1) begin n_bad++; $display("FAIL b2b_cos got %0d want 0", c); end
    endtask

    task automatic test_reset_mid();
        int s, c, lat;
        bit seen = 0;
        while (!angle_ready_out) @(negedge clk_in);
        angle_in = 16'h2000;
        angle_valid_in = 1;
        @(negedge clk_in);
        angle_valid_in = 0;
        repeat (7) @(negedge clk_in);
        rst_in = 1;
        #1;
        n_cmp += 4;
        if (sin_out !== 16'sd0) begin n_bad++; $display("FAIL midrst_sin got %0d want 0", sin_out); end
        if (cos_out !== 16'sd256) begin n_bad++; $display("FAIL midrst_cos got %0d want 256", cos_out); end
        if (valid_out !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %b want 0", valid_out); end
        if (angle_ready_out !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got %b want 1", angle_ready_out); end
        @(negedge clk_in);
        rst_in = 0;
        repeat (20) begin
            @(negedge clk_in);
            if (valid_out) seen = 1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_no_valid got %b want 0", seen); end
        run_angle(16'hE000, s, c, lat);
        n_cmp += 3;
        if (lat !== 15) begin n_bad++; $display("FAIL midrst_latency got %0d want 15", lat); end
        if (s < -183 || s > -180) begin n_bad++; $display("FAIL midrst_sin_after got %0d want -181", s); end
        if (c < 179 || c > 182) begin n_bad++; $display("FAIL midrst_cos_after got %0d want 181", c); end
    endtask

    task automatic test_sweep();
        int s, c, lat;
        real ph, es, ec;
        logic [15:0] a;
        for (int k = 0; k < 64; k++) begin
            a = 16'(k * 1031 + 7);
            run_angle(a, s, c, lat);
            ph = 2.0 * 3.14159265358979 * $itor(a) / 65536.0;
            es = 256.0 * $sin(ph);
            ec = 256.0 * $cos(ph);
            n_cmp += 3;
            if (lat !== 15) begin n_bad++; $display("FAIL sweep_latency_%h got %0d want 15", a, lat); end
            if ($itor(s) - es < -2.5 || $itor(s) - es > 1.5 || s > 256 || s < -256)
                begin n_bad++; $display("FAIL sweep_sin_%h got %0d want %f", a, s, es); end
            if ($itor(c) - ec < -2.5 || $itor(c) - ec > 1.5 || c > 256 || c < -256)
                begin n_bad++; $display("FAIL sweep_cos_%h got %0d want %f", a, c, ec); end
        end
    endtask

    initial begin
        test_reset();
        test_axis_diag();
        test_hold_during_rotate();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sincos_cordic.md
# sincos_cordic

Iterative CORDIC engine that converts a 16-bit rotation angle into the signed sine/cosine pair consumed by the vertex rotation datapath. It sits upstream of the triangle rotate/scale stage and drives its `sin_val`/`cos_val` operands. Outputs use the same Q8 format that stage expects, where 256 = 1.0. One angle is accepted per transaction, and the result is held stable until the next one completes.

## Interface
- `ITER`, default 14: number of CORDIC micro-rotations. Legal range is 8–16.
- `FRAC`, default 14: fractional bits of the internal x/y datapath.
- `clk_in`, input, 1: system clock. All state changes on the rising edge.
- `rst_in`, input, 1: reset. Asynchronous and active-high.
- `angle_in`, input, 16: unsigned angle. 65536 = one full turn, so 0x4000 = 90°.
- `angle_valid_in`, input, 1: `angle_in` is valid.
- `angle_ready_out`, output, 1: the engine can accept an angle. High only in IDLE.
- `sin_out`, output, 16: signed Q8 sine, in the range [-256, 256].
- `cos_out`, output, 16: signed Q8 cosine, in the range [-256, 256].
- `valid_out`, output, 1: one-cycle pulse when `sin_out`/`cos_out` update.

## Operation
- **States:**
  - IDLE → ROTATE when `angle_valid_in && angle_ready_out`.
  - ROTATE → DONE after `ITER` iterations.
  - DONE → IDLE unconditionally.
- **Accept (IDLE):**
  - Quadrant fold: if `angle_in[15:14]` is 01 or 10, set `flip = 1` and `z = angle_in - 0x8000`. Otherwise `flip = 0` and `z = angle_in`.
  - Interpret `z` as signed 16-bit. It is now within [-0x4000, 0x4000].
  - Load `x = K`, `y = 0`, `i = 0`. K = round(0.6072529 · 2^FRAC), which is 9949 for FRAC = 14.
- **ROTATE, per cycle:**
  - `d = (z >= 0)`.
  - If `d`: `x -= y>>>i`, `y += x>>>i`, `z -= ATAN[i]`.
  - If not `d`: `x += y>>>i`, `y -= x>>>i`, `z += ATAN[i]`.
  - Both updates use the old x and y. `i` increments.
- **Datapath widths:**
  - x and y are signed, FRAC+3 bits wide. This guarantees no overflow including the CORDIC gain.
  - z is signed 17 bits.
- **DONE:**
  - Convert x→cos and y→sin to Q8 with a right shift of FRAC-8 (see Configuration).
  - Negate both if `flip`.
  - Saturate to [-256, 256] and register into `sin_out`/`cos_out`.
  - Pulse `valid_out`.
- **Handshake rules:**
  - `angle_valid_in` is ignored outside IDLE. There is no queueing, so the producer must hold it until it sees ready.
  - `angle_in` is sampled only at the accept edge; later changes have no effect.
- **Reset values:**
  - State = IDLE, `angle_ready_out = 1`, `sin_out = 0`, `cos_out = 256`, `valid_out = 0`.
  - Reset mid-ROTATE abandons the transaction with no `valid_out`.
- `sin_out`/`cos_out` hold their last value in all states except the DONE update.

## Timing
- Accept edge E0. ROTATE occupies edges E1..E_ITER. `sin_out`/`cos_out`/`valid_out` register at edge E_ITER+1.
- Latency from accept to `valid_out` is ITER+1 cycles, i.e. 15 at the defaults.
- `angle_ready_out` is low from E0 through E_ITER+1 and high again in the cycle `valid_out` is high.
- Back-to-back accept is allowed in that cycle. Throughput is one result per ITER+2 cycles.
- `valid_out` is high for exactly one cycle per accepted angle.

## Configuration
- `SINCOS_ROUND_EN` defined: Q8 conversion rounds half-up, i.e. `(v + 2^(FRAC-9)) >>> (FRAC-8)`.
- `SINCOS_ROUND_EN` undefined: plain arithmetic-shift truncation toward −∞.
- Saturation and negation are identical in both builds.
- The ±1 LSB tolerance below holds only with rounding enabled. The truncating build is allowed −2..+1 LSB.

## Structure
- Package `sincos_pkg` holds:
  - the `ATAN` table, 16 entries of atan(2^-i)·65536/(2π) rounded to integers (8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0);
  - the constant K per FRAC;
  - the Q8 constants ONE_Q8 = 256 and MINUS_ONE_Q8 = -256;
  - the state enum.
- One sub-module, `cordic_stage`: a combinational single micro-rotation taking (x, y, z, i) and returning the next (x, y, z). It is instantiated once and reused every cycle by the FSM.

## Test plan
- **Reset values:** assert `rst_in` → `sin_out = 0`, `cos_out = 256`, `valid_out = 0`, `angle_ready_out = 1`.
- **Axis angles:**
  - `angle_in = 0x0000` → cos 256, sin 0 (±1), with `valid_out` exactly 15 cycles after accept.
  - `0x4000` → sin 256, cos 0.
  - `0x8000` → cos −256, sin 0 (fold path).
  - `0xC000` → sin −256, cos 0.
- **Diagonals:** `0x2000` → sin 181, cos 181. `0xE000` → sin −181, cos 181. `0xA000` → sin −181, cos −181. All ±1 LSB.
- **Handshake:**
  - Toggle `angle_in` and `angle_valid_in` during ROTATE → no effect, result matches the accepted angle.
  - Assert valid in the `valid_out` cycle → accepted immediately, second result follows 16 cycles after the first.
- **Reset mid-operation:** assert `rst_in` at cycle 7 of ROTATE → no `valid_out`, outputs return to their reset values, next accept yields a correct result.
- **Sweep:** all 65536 angles against a reference model → error within tolerance, no value outside [-256, 256].
